// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller for the five-stage MIPS core. It merges the ID, EX
// and MEM stall requests, sequences the iterative divider and counts stalled cycles.
module pipe_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_stallreq_i,
   input  logic        ex_div_req_i,
   input  logic        div_done_i,
   input  logic        mem_stallreq_i,
   input  logic        flush_i,
   output logic [5:0]  stall_o,
   output logic        flush_o,
   output logic        div_start_o,
   output logic        div_cancel_o,
   output logic [31:0] stall_cnt_o,
   output logic [1:0]  div_state_o
);

   // Handshake with the divider: div_start_o launches one operation; the divider
   // answers with a single div_done_i pulse. div_cancel_o aborts an operation in
   // flight. Start and cancel are registered single-cycle pulses, never high together.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } div_state_t;

   div_state_t state;
   logic       ex_stall;

   assign div_state_o = state;

   // DONE releases EX so the quotient can advance without restarting the same DIV.
   assign ex_stall = ((state == S_IDLE) && ex_div_req_i) || (state == S_RUN);

   always_comb begin
      stall_o = 6'b000000;
      if (!rst)                stall_o = 6'b000000;
      else if (flush_i)        stall_o = 6'b000000;
      else if (mem_stallreq_i) stall_o = 6'b011111;
      else if (ex_stall)       stall_o = 6'b001111;
      else if (id_stallreq_i)  stall_o = 6'b000111;
   end

   assign flush_o = flush_i & rst;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= S_IDLE;
         div_start_o  <= 1'b0;
         div_cancel_o <= 1'b0;
         stall_cnt_o  <= 32'd0;
      end else begin
         div_start_o  <= 1'b0;
         div_cancel_o <= 1'b0;

         if (stall_o[0] && (stall_cnt_o != 32'hFFFF_FFFF))
            stall_cnt_o <= stall_cnt_o + 32'd1;

         if (flush_i) begin
            // A flush wins over a same-cycle div_done_i; only a running op needs aborting.
            state        <= S_IDLE;
            div_cancel_o <= (state == S_RUN);
         end else begin
            case (state)
               S_IDLE: begin
                  if (ex_div_req_i) begin
                     state       <= S_RUN;
                     div_start_o <= 1'b1;
                  end
               end
               S_RUN: begin
                  if (div_done_i) state <= S_DONE;
               end
               S_DONE: begin
                  if (!stall_o[3]) state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a per-cycle vector table plus hand-written
// sequences for back-to-back divides and reset during RUN.
module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic        id_stallreq_i;
   logic        ex_div_req_i;
   logic        div_done_i;
   logic        mem_stallreq_i;
   logic        flush_i;
   logic [5:0]  stall_o;
   logic        flush_o;
   logic        div_start_o;
   logic        div_cancel_o;
   logic [31:0] stall_cnt_o;
   logic [1:0]  div_state_o;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

   typedef struct {
      logic        rst, id, dreq, done, mem, flush;
      logic [5:0]  stall;
      logic        fl, start, cancel;
      logic [1:0]  state;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs[$];

   pipe_ctrl dut (
      .clk(clk), .rst(rst),
      .id_stallreq_i(id_stallreq_i), .ex_div_req_i(ex_div_req_i),
      .div_done_i(div_done_i), .mem_stallreq_i(mem_stallreq_i),
      .flush_i(flush_i), .stall_o(stall_o), .flush_o(flush_o),
      .div_start_o(div_start_o), .div_cancel_o(div_cancel_o),
      .stall_cnt_o(stall_cnt_o), .div_state_o(div_state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic id, input logic dreq,
                        input logic done, input logic mem, input logic fl);
      rst = r; id_stallreq_i = id; ex_div_req_i = dreq;
      div_done_i = done; mem_stallreq_i = mem; flush_i = fl;
   endtask

   task automatic add(input logic r, input logic id, input logic dreq, input logic done,
                      input logic mem, input logic fl, input logic [5:0] st, input logic efl,
                      input logic es, input logic ec, input logic [1:0] sta, input int c);
      vec_t v;
      v.rst = r; v.id = id; v.dreq = dreq; v.done = done; v.mem = mem; v.flush = fl;
      v.stall = st; v.fl = efl; v.start = es; v.cancel = ec; v.state = sta; v.cnt = c;
      vecs.push_back(v);
   endtask

   initial begin
      drive(0, 1, 1, 1, 1, 1);
      @(posedge clk);

      //  rst id dq dn mm fl   stall      fl st cn state cnt
      add(0, 1, 1, 1, 1, 1, 6'b000000, 0, 0, 0, IDLE, 0);   // reset, all requests high
      add(0, 1, 1, 1, 1, 1, 6'b000000, 0, 0, 0, IDLE, 0);
      add(1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, IDLE, 0);
      add(1, 1, 0, 0, 0, 0, 6'b000111, 0, 0, 0, IDLE, 0);   // load-use
      add(1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, IDLE, 1);
      add(1, 0, 1, 0, 0, 0, 6'b001111, 0, 0, 0, IDLE, 1);   // divide, done 5 after start
      add(1, 0, 1, 0, 0, 0, 6'b001111, 0, 1, 0, RUN,  2);
      add(1, 0, 1, 0, 0, 0, 6'b001111, 0, 0, 0, RUN,  3);
      add(1, 0, 1, 0, 0, 0, 6'b001111, 0, 0, 0, RUN,  4);
      add(1, 0, 1, 0, 0, 0, 6'b001111, 0, 0, 0, RUN,  5);
      add(1, 0, 1, 1, 0, 0, 6'b001111, 0, 0, 0, RUN,  6);
      add(1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, DONE, 7);
      add(1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, IDLE, 7);
      add(1, 0, 1, 0, 0, 0, 6'b001111, 0, 0, 0, IDLE, 7);   // short divide, MEM stall in DONE
      add(1, 0, 1, 1, 0, 0, 6'b001111, 0, 1, 0, RUN,  8);
      add(1, 0, 1, 0, 1, 0, 6'b011111, 0, 0, 0, DONE, 9);
      add(1, 0, 1, 0, 1, 0, 6'b011111, 0, 0, 0, DONE, 10);
      add(1, 0, 1, 0, 1, 0, 6'b011111, 0, 0, 0, DONE, 11);
      add(1, 0, 1, 0, 0, 0, 6'b000000, 0, 0, 0, DONE, 12);
      add(1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, IDLE, 12);
      add(1, 0, 1, 0, 0, 0, 6'b001111, 0, 0, 0, IDLE, 12);  // flush + done in RUN
      add(1, 0, 1, 0, 0, 0, 6'b001111, 0, 1, 0, RUN,  13);
      add(1, 0, 1, 1, 0, 1, 6'b000000, 1, 0, 0, RUN,  14);
      add(1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1, IDLE, 14);
      add(1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, IDLE, 14);
      add(1, 1, 1, 0, 1, 0, 6'b011111, 0, 0, 0, IDLE, 14);  // priority
      add(1, 1, 1, 0, 0, 0, 6'b001111, 0, 1, 0, RUN,  15);
      add(1, 0, 0, 0, 0, 1, 6'b000000, 1, 0, 0, RUN,  16);
      add(1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1, IDLE, 16);
      add(1, 0, 1, 0, 0, 1, 6'b000000, 1, 0, 0, IDLE, 16);  // flush in IDLE: no start
      add(1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, IDLE, 16);
      add(1, 0, 0, 1, 0, 0, 6'b000000, 0, 0, 0, IDLE, 16);  // stray done ignored
      add(1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, IDLE, 16);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].id, vecs[i].dreq, vecs[i].done, vecs[i].mem, vecs[i].flush);
         #1;
         check($sformatf("v%0d stall", i),  32'(stall_o),      32'(vecs[i].stall));
         check($sformatf("v%0d flush", i),  32'(flush_o),      32'(vecs[i].fl));
         check($sformatf("v%0d start", i),  32'(div_start_o),  32'(vecs[i].start));
         check($sformatf("v%0d cancel", i), 32'(div_cancel_o), 32'(vecs[i].cancel));
         check($sformatf("v%0d state", i),  32'(div_state_o),  32'(vecs[i].state));
         check($sformatf("v%0d cnt", i),    stall_cnt_o,       vecs[i].cnt);
      end

      // Back-to-back DIVs (k=2), then reset in the middle of RUN.
      @(negedge clk); drive(1, 0, 1, 0, 0, 0); #1;
      check("b2b c0 stall", 32'(stall_o), 32'h0F);
      check("b2b c0 state", 32'(div_state_o), 32'(IDLE));
      @(negedge clk); drive(1, 0, 1, 0, 0, 0); #1;
      check("b2b c1 start", 32'(div_start_o), 32'd1);
      check("b2b c1 state", 32'(div_state_o), 32'(RUN));
      @(negedge clk); drive(1, 0, 1, 1, 0, 0); #1;
      check("b2b c2 start", 32'(div_start_o), 32'd0);
      check("b2b c2 stall", 32'(stall_o), 32'h0F);
      @(negedge clk); drive(1, 0, 0, 0, 0, 0); #1;
      check("b2b c3 state", 32'(div_state_o), 32'(DONE));
      check("b2b c3 stall", 32'(stall_o), 32'h00);
      @(negedge clk); drive(1, 0, 1, 0, 0, 0); #1;
      check("b2b c4 state", 32'(div_state_o), 32'(IDLE));
      check("b2b c4 stall", 32'(stall_o), 32'h0F);
      @(negedge clk); drive(1, 0, 1, 0, 0, 0); #1;
      check("b2b c5 start", 32'(div_start_o), 32'd1);
      check("b2b c5 state", 32'(div_state_o), 32'(RUN));
      @(negedge clk); drive(0, 0, 1, 0, 1, 1); #1;
      check("rst run stall", 32'(stall_o), 32'h00);
      check("rst run flush", 32'(flush_o), 32'd0);
      @(negedge clk); drive(1, 0, 0, 0, 0, 0); #1;
      check("rst run state", 32'(div_state_o), 32'(IDLE));
      check("rst run cancel", 32'(div_cancel_o), 32'd0);
      check("rst run start", 32'(div_start_o), 32'd0);
      check("rst run cnt", stall_cnt_o, 32'd0);
      @(negedge clk); #1;
      check("rst run cancel2", 32'(div_cancel_o), 32'd0);
      check("rst run idle2", 32'(div_state_o), 32'(IDLE));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
